// File: rtl/alu_pkg.sv
// Shared definitions for the bit-serial ALU sequencer: op codes, ctrl field positions, FSM states.
package alu_pkg;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_SLT = 2'b11;

  localparam int unsigned CTRL_AINV  = 3;
  localparam int unsigned CTRL_BINV  = 2;
  localparam int unsigned CTRL_OP_HI = 1;
  localparam int unsigned CTRL_OP_LO = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/serial_bit_operand.sv
// One-bit ALU slice: builds the four mux candidates and the ripple carry for a single bit.
module serial_bit_operand (
  input  logic       i_a,
  input  logic       i_b,
  input  logic       i_c,
  input  logic       i_ainv,
  input  logic       i_binv,
  output logic [0:3] o_data,
  output logic       o_carry
);

  logic w_a;
  logic w_b;

  assign w_a     = i_a ^ i_ainv;
  assign w_b     = i_b ^ i_binv;
  // [0]=AND [1]=OR [2]=SUM [3]=LESS (LESS is only non-zero in the fix-up cycle)
  assign o_data  = {w_a & w_b, w_a | w_b, w_a ^ w_b ^ i_c, 1'b0};
  assign o_carry = (w_a & w_b) | (w_a & i_c) | (w_b & i_c);

endmodule

// File: rtl/serial_alu_sequencer.sv
// Bit-serial ALU controller: feeds an external 4:1 result mux one bit per cycle, LSB first,
// collects the selected bit, then applies the SLT fix-up and publishes result and flags.
module serial_alu_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  input  logic [3:0]       ctrl_i,
  output logic [0:3]       mux_data_o,
  output logic [1:0]       mux_sel_o,
  input  logic             mux_out_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             cout_o,
  output logic             overflow_o,
  output logic             done_o
);

  localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_work;
  logic             r_ainv;
  logic             r_binv;
  logic [1:0]       r_op;
  logic             r_carry;
  logic [IW-1:0]    r_idx;
  logic             r_set;
  logic             r_cout;
  logic             r_ovf;

  logic             w_accept;
  logic             w_last;
  logic [0:3]       w_data;
  logic             w_carry;
  logic             w_ovf;
  logic             w_fix_bit;
  logic [WIDTH-1:0] w_final;

  serial_bit_operand u_bit (
    .i_a     (r_a[r_idx]),
    .i_b     (r_b[r_idx]),
    .i_c     (r_carry),
    .i_ainv  (r_ainv),
    .i_binv  (r_binv),
    .o_data  (w_data),
    .o_carry (w_carry)
  );

  assign w_accept  = ready_o & start_i;
  assign w_last    = (r_idx == IW'(WIDTH - 1));
  assign w_ovf     = r_carry ^ w_carry;
  assign w_fix_bit = (r_op == OP_SLT) ? mux_out_i : r_work[0];
  assign w_final   = {r_work[WIDTH-1:1], w_fix_bit};

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: if (start_i) w_next = ST_RUN;
      ST_RUN:  if (w_last)  w_next = ST_FIX;
      ST_FIX:  w_next = ST_DONE;
      ST_DONE: w_next = start_i ? ST_RUN : ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    ready_o    = 1'b0;
    done_o     = 1'b0;
    mux_data_o = '0;
    mux_sel_o  = '0;
    unique case (r_state)
      ST_IDLE: ready_o = 1'b1;
      ST_RUN: begin
        mux_data_o = w_data;
        mux_sel_o  = r_op;
      end
      ST_FIX: begin
        if (r_op == OP_SLT) begin
          mux_data_o = {3'b000, r_set};
          mux_sel_o  = OP_SLT;
        end
      end
      ST_DONE: begin
        ready_o = 1'b1;
        done_o  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_a        <= '0;
      r_b        <= '0;
      r_work     <= '0;
      r_ainv     <= 1'b0;
      r_binv     <= 1'b0;
      r_op       <= '0;
      r_carry    <= 1'b0;
      r_idx      <= '0;
      r_set      <= 1'b0;
      r_cout     <= 1'b0;
      r_ovf      <= 1'b0;
      result_o   <= '0;
      zero_o     <= 1'b0;
      cout_o     <= 1'b0;
      overflow_o <= 1'b0;
    end else begin
      if (w_accept) begin
        r_a     <= src1_i;
        r_b     <= src2_i;
        r_ainv  <= ctrl_i[CTRL_AINV];
        r_binv  <= ctrl_i[CTRL_BINV];
        r_op    <= ctrl_i[CTRL_OP_HI:CTRL_OP_LO];
        r_carry <= ctrl_i[CTRL_BINV];
        r_idx   <= '0;
      end else if (r_state == ST_RUN) begin
        r_work[r_idx] <= mux_out_i;
        r_carry       <= w_carry;
        r_idx         <= r_idx + 1'b1;
        if (w_last) begin
          r_cout <= w_carry;
          r_ovf  <= w_ovf;
          r_set  <= w_data[2] ^ w_ovf;
        end
      end else if (r_state == ST_FIX) begin
        result_o   <= w_final;
        zero_o     <= (w_final == '0);
        cout_o     <= r_cout;
        overflow_o <= r_ovf;
      end
    end
  end

endmodule

// File: tb/tb_serial_alu_sequencer.sv
// Directed bench for serial_alu_sequencer (WIDTH=32) with a behavioural 4:1 result mux on the mux ports.
module tb_serial_alu_sequencer;

  localparam int unsigned W = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          ready;
  logic [W-1:0]  src1 = '0;
  logic [W-1:0]  src2 = '0;
  logic [3:0]    ctrl = '0;
  logic [0:3]    mux_data;
  logic [1:0]    mux_sel;
  logic          mux_out;
  logic [W-1:0]  result;
  logic          zero;
  logic          cout;
  logic          ovf;
  logic          done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign mux_out = mux_data[mux_sel];

  serial_alu_sequencer #(.WIDTH(W)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start),
    .ready_o    (ready),
    .src1_i     (src1),
    .src2_i     (src2),
    .ctrl_i     (ctrl),
    .mux_data_o (mux_data),
    .mux_sel_o  (mux_sel),
    .mux_out_i  (mux_out),
    .result_o   (result),
    .zero_o     (zero),
    .cout_o     (cout),
    .overflow_o (ovf),
    .done_o     (done)
  );

  // Launches one op and returns the number of edges from acceptance to the done_o cycle (0 = timeout).
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] c,
                        output int lat);
    @(negedge clk);
    src1 = a; src2 = b; ctrl = c; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    src1 = $urandom(); src2 = $urandom(); ctrl = 4'($urandom());
    lat = 0;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({ready, done} !== 2'b10) begin
      errors++; $display("FAIL reset_handshake got ready/done=%b expected 10", {ready, done});
    end
    checks++;
    if ({result, zero, cout, ovf, mux_data, mux_sel} !== '0) begin
      errors++; $display("FAIL reset_outputs got result=%h z=%b c=%b v=%b data=%b sel=%b expected all 0",
                         result, zero, cout, ovf, mux_data, mux_sel);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_add();
    int lat;
    run_op(32'h7FFF_FFFF, 32'h0000_0001, 4'b0010, lat);
    checks++;
    if (lat !== 33) begin
      errors++; $display("FAIL add_latency got %0d expected 33", lat);
    end
    checks++;
    if ({result, zero, cout, ovf} !== {32'h8000_0000, 1'b0, 1'b0, 1'b1}) begin
      errors++; $display("FAIL add_result got %h z=%b c=%b v=%b expected 80000000 z=0 c=0 v=1",
                         result, zero, cout, ovf);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("FAIL add_done_pulse got done=%b one cycle later expected 0", done);
    end
  endtask

  task automatic test_sub();
    int lat;
    run_op(32'd5, 32'd5, 4'b0110, lat);
    checks++;
    if (lat !== 33 || {result, zero, cout, ovf} !== {32'h0, 1'b1, 1'b1, 1'b0}) begin
      errors++; $display("FAIL sub_5_5 got lat=%0d %h z=%b c=%b v=%b expected 33 00000000 z=1 c=1 v=0",
                         lat, result, zero, cout, ovf);
    end
  endtask

  task automatic test_slt();
    int lat;
    run_op(32'hFFFF_FFFF, 32'h0000_0001, 4'b0111, lat);
    checks++;
    if (lat !== 33 || result !== 32'h1 || zero !== 1'b0) begin
      errors++; $display("FAIL slt_neg got lat=%0d %h z=%b expected 33 00000001 z=0", lat, result, zero);
    end
    run_op(32'h8000_0000, 32'h7FFF_FFFF, 4'b0111, lat);
    checks++;
    if (lat !== 33 || result !== 32'h1 || ovf !== 1'b1 || cout !== 1'b1) begin
      errors++; $display("FAIL slt_ovf got lat=%0d %h v=%b c=%b expected 33 00000001 v=1 c=1",
                         lat, result, ovf, cout);
    end
    run_op(32'd3, 32'd3, 4'b0111, lat);
    checks++;
    if (lat !== 33 || result !== 32'h0 || zero !== 1'b1) begin
      errors++; $display("FAIL slt_equal got lat=%0d %h z=%b expected 33 00000000 z=1", lat, result, zero);
    end
  endtask

  task automatic test_logic();
    int lat;
    run_op(32'h0, 32'h0, 4'b1100, lat);
    checks++;
    if (lat !== 33 || result !== 32'hFFFF_FFFF || zero !== 1'b0 || cout !== 1'b1) begin
      errors++; $display("FAIL nor got lat=%0d %h z=%b c=%b expected 33 ffffffff z=0 c=1",
                         lat, result, zero, cout);
    end
    run_op(32'hF0F0_F0F0, 32'hFF00_FF00, 4'b0000, lat);
    checks++;
    if (lat !== 33 || result !== 32'hF000_F000) begin
      errors++; $display("FAIL and got lat=%0d %h expected 33 f000f000", lat, result);
    end
    run_op(32'hF0F0_F0F0, 32'hFF00_FF00, 4'b0001, lat);
    checks++;
    if (lat !== 33 || result !== 32'hFFF0_FFF0) begin
      errors++; $display("FAIL or got lat=%0d %h expected 33 fff0fff0", lat, result);
    end
  endtask

  task automatic test_abort();
    int seen;
    @(negedge clk);
    src1 = 32'h1234_5678; src2 = 32'h1111_1111; ctrl = 4'b0010; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (ready !== 1'b0 || mux_sel !== 2'b10) begin
      errors++; $display("FAIL abort_midrun got ready=%b sel=%b expected ready=0 sel=10", ready, mux_sel);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if ({ready, done} !== 2'b10 || {result, zero, cout, ovf, mux_data, mux_sel} !== '0) begin
      errors++; $display("FAIL abort_reset got ready=%b done=%b result=%h z=%b c=%b v=%b data=%b sel=%b expected ready=1 rest 0",
                         ready, done, result, zero, cout, ovf, mux_data, mux_sel);
    end
    seen = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++; $display("FAIL abort_no_done got %0d done pulses expected 0", seen);
    end
  endtask

  task automatic test_ignore_start();
    int lat;
    @(negedge clk);
    src1 = 32'd1; src2 = 32'd2; ctrl = 4'b0010; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    src1 = 32'hDEAD_BEEF; src2 = 32'hCAFE_F00D; ctrl = 4'b0001; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = 0;
    for (int n = 7; n <= 60; n++) begin
      @(posedge clk); #1;
      if (done) begin lat = n; break; end
    end
    checks++;
    if (lat !== 33 || result !== 32'd3) begin
      errors++; $display("FAIL ignore_start got lat=%0d %h expected 33 00000003", lat, result);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    run_op(32'd10, 32'd20, 4'b0010, lat);
    checks++;
    if (lat !== 33 || result !== 32'd30) begin
      errors++; $display("FAIL b2b_first got lat=%0d %h expected 33 0000001e", lat, result);
    end
    src1 = 32'd100; src2 = 32'd1; ctrl = 4'b0110; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    src1 = '0; src2 = '0;
    lat = 0;
    for (int n = 2; n <= 70; n++) begin
      @(posedge clk); #1;
      if (done) begin lat = n; break; end
    end
    checks++;
    if (lat !== 34 || result !== 32'd99 || cout !== 1'b1 || zero !== 1'b0) begin
      errors++; $display("FAIL b2b_second got lat=%0d %h c=%b z=%b expected 34 00000063 c=1 z=0",
                         lat, result, cout, zero);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_slt();
    test_logic();
    test_abort();
    test_ignore_start();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
